// File: rtl/bht_update_fifo_pkg.sv
// Shared types for the BHT update FIFO slice.
//   cva6_cfg_t     : subset of the core configuration used here (VLEN, DebugEn).
//   cva6_cfg_empty : default configuration (32-bit VLEN, debug support enabled).
//   bht_update_t   : BHT update payload {valid, pc, taken}.
//   ptr_width()    : pointer width for a given entry count (at least 1 bit).
package bht_update_fifo_pkg;

    localparam int unsigned DEFAULT_VLEN = 32;

    typedef struct packed {
        int unsigned VLEN;
        logic        DebugEn;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: DEFAULT_VLEN, DebugEn: 1'b1};

    typedef struct packed {
        logic                    valid;
        logic [DEFAULT_VLEN-1:0] pc;
        logic                    taken;
    } bht_update_t;

    // Pointer width; a single-entry queue still needs one pointer bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bht_update_fifo_store.sv
// Non-fall-through FIFO storage with a dedicated occupancy counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset (pointers/usage only).
//   flush_i       : empty the queue at the next edge; a same-cycle push is lost.
//   push_i/data_i : write request; accepted when not full or when popping.
//   pop_i         : consume the head entry (ignored when empty).
//   data_o        : storage[rptr], raw (caller masks with empty_o).
//   usage_o       : occupancy, full_o/empty_o derived from it.
module bht_update_fifo_store
    import bht_update_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 33
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         pop_i,
    output logic [DATA_W-1:0]            data_o,
    output logic [$clog2(DEPTH+1)-1:0]   usage_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned USE_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [USE_W-1:0]  usage_q, usage_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              full, empty;
    logic              push_ok, pop_ok;

    assign full  = (usage_q == USE_W'(DEPTH));
    assign empty = (usage_q == '0);

    // Pointer, occupancy and storage next-state.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        usage_d = usage_q;
        mem_d   = mem_q;
        pop_ok  = pop_i & ~empty;
        // A full queue still takes a push when the head leaves in the same cycle.
        push_ok = push_i & (~full | pop_ok);

        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            usage_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wptr_q] = data_i;
                wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   usage_d = usage_q + USE_W'(1);
                2'b01:   usage_d = usage_q - USE_W'(1);
                default: usage_d = usage_q;
            endcase
        end
    end

    // Control state; the only state that needs a reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            usage_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            usage_q <= usage_d;
        end
    end

    // Payload storage is not reset; empty masks stale contents downstream.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign data_o  = mem_q[rptr_q];
    assign usage_o = usage_q;
    assign full_o  = full;
    assign empty_o = empty;

endmodule

// File: rtl/bht_update_fifo.sv
// Buffers resolved conditional branches between the branch unit and the BHT.
//   clk_i, rst_ni        : clock, asynchronous active-low reset.
//   flush_bp_i           : drop all queued updates (and any same-cycle push).
//   debug_mode_i         : suppresses new pushes when debug support is enabled.
//   resolved_*_i         : branch resolution from execute.
//   bht_ready_i          : BHT consumes the head entry this cycle.
//   bht_update_o         : head entry, all-zero while empty.
//   usage_o / full_o     : occupancy and full flag.
//   drop_cnt_o           : saturating count of resolutions lost to overflow.
module bht_update_fifo #(
    parameter bht_update_fifo_pkg::cva6_cfg_t CVA6Cfg = bht_update_fifo_pkg::cva6_cfg_empty,
    parameter type         bht_update_t = bht_update_fifo_pkg::bht_update_t,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_bp_i,
    input  logic                        debug_mode_i,
    input  logic                        resolved_valid_i,
    input  logic                        resolved_is_cond_i,
    input  logic [CVA6Cfg.VLEN-1:0]     resolved_pc_i,
    input  logic                        resolved_taken_i,
    input  logic                        bht_ready_i,
    output bht_update_t                 bht_update_o,
    output logic [$clog2(DEPTH+1)-1:0]  usage_o,
    output logic                        full_o,
    output logic [CNT_WIDTH-1:0]        drop_cnt_o
);

    localparam int unsigned VLEN   = CVA6Cfg.VLEN;
    localparam int unsigned DATA_W = VLEN + 1;
    localparam int unsigned USE_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 push_req;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [DATA_W-1:0]    head_data;
    logic [USE_W-1:0]     usage;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    // Only conditional branches outside debug mode reach the BHT; flush wins over push.
    assign push_req = resolved_valid_i & resolved_is_cond_i
                    & ~(CVA6Cfg.DebugEn & debug_mode_i) & ~flush_bp_i;
    assign pop      = ~empty & bht_ready_i;

    bht_update_fifo_store #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_store (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_bp_i),
        .push_i  (push_req),
        .data_i  ({resolved_pc_i, resolved_taken_i}),
        .pop_i   (pop),
        .data_o  (head_data),
        .usage_o (usage),
        .full_o  (full),
        .empty_o (empty)
    );

    // Overflow drop counter: counts only pushes the queue had to refuse.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (push_req && full && !pop && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Head presentation; unreset storage is hidden while empty.
    always_comb begin
        bht_update_o = '0;
        if (!empty) begin
            bht_update_o.valid = 1'b1;
            bht_update_o.pc    = head_data[DATA_W-1:1];
            bht_update_o.taken = head_data[0];
        end
    end

    assign usage_o    = usage;
    assign full_o     = full;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bht_update_fifo.sv
module tb_bht_update_fifo;
    import bht_update_fifo_pkg::*;

    localparam cva6_cfg_t CFG_A = '{VLEN: 32, DebugEn: 1'b1};
    localparam cva6_cfg_t CFG_B = '{VLEN: 32, DebugEn: 1'b0};

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    // Instance A: DebugEn=1, 8-bit drop counter.
    logic        flush_a, dbg_a, rv_a, rc_a, rt_a, rdy_a;
    logic [31:0] rpc_a;
    bht_update_t upd_a;
    logic [2:0]  usage_a;
    logic        full_a;
    logic [7:0]  drop_a;

    // Instance B: DebugEn=0, 2-bit drop counter.
    logic        flush_b, dbg_b, rv_b, rc_b, rt_b, rdy_b;
    logic [31:0] rpc_b;
    bht_update_t upd_b;
    logic [2:0]  usage_b;
    logic        full_b;
    logic [1:0]  drop_b;

    bht_update_fifo #(.CVA6Cfg(CFG_A), .DEPTH(4), .CNT_WIDTH(8)) u_dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_bp_i(flush_a), .debug_mode_i(dbg_a),
        .resolved_valid_i(rv_a), .resolved_is_cond_i(rc_a), .resolved_pc_i(rpc_a),
        .resolved_taken_i(rt_a), .bht_ready_i(rdy_a), .bht_update_o(upd_a),
        .usage_o(usage_a), .full_o(full_a), .drop_cnt_o(drop_a)
    );

    bht_update_fifo #(.CVA6Cfg(CFG_B), .DEPTH(4), .CNT_WIDTH(2)) u_dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_bp_i(flush_b), .debug_mode_i(dbg_b),
        .resolved_valid_i(rv_b), .resolved_is_cond_i(rc_b), .resolved_pc_i(rpc_b),
        .resolved_taken_i(rt_b), .bht_ready_i(rdy_b), .bht_update_o(upd_b),
        .usage_o(usage_b), .full_o(full_b), .drop_cnt_o(drop_b)
    );

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_a(input logic [31:0] pc, input logic taken);
        rv_a = 1'b1; rc_a = 1'b1; rpc_a = pc; rt_a = taken;
    endtask

    task automatic idle_a();
        rv_a = 1'b0; rc_a = 1'b0; rpc_a = '0; rt_a = 1'b0;
    endtask

    task automatic push_b(input logic [31:0] pc, input logic taken);
        rv_b = 1'b1; rc_b = 1'b1; rpc_b = pc; rt_b = taken;
    endtask

    task automatic idle_b();
        rv_b = 1'b0; rc_b = 1'b0; rpc_b = '0; rt_b = 1'b0;
    endtask

    // Monitor: every head entry the BHT consumes must match the scoreboard front.
    always @(negedge clk_i) begin
        if (rst_ni && !flush_a && upd_a.valid && rdy_a) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_pop: got pc 0x%0h with nothing expected", upd_a.pc);
            end else begin
                exp_e = exp_q.pop_front();
                if ({upd_a.pc, upd_a.taken} !== exp_e) begin
                    errors++;
                    $display("FAIL scoreboard_pop: got pc 0x%0h taken %0b expected pc 0x%0h taken %0b",
                             upd_a.pc, upd_a.taken, exp_e[32:1], exp_e[0]);
                end
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        flush_a = 0; dbg_a = 0; rdy_a = 0; idle_a();
        flush_b = 0; dbg_b = 0; rdy_b = 0; idle_b();
        repeat (3) step();

        // Reset values
        chk("reset_upd_a", 64'(upd_a), 64'd0);
        chk("reset_usage_a", 64'(usage_a), 64'd0);
        chk("reset_full_a", 64'(full_a), 64'd0);
        chk("reset_drop_a", 64'(drop_a), 64'd0);
        chk("reset_drop_b", 64'(drop_b), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // Single push with ready: visible one cycle later, gone the next
        rdy_a = 1'b1;
        chk("t1_usage_before", 64'(usage_a), 64'd0);
        push_a(32'h8000_0010, 1'b1);
        exp_q.push_back({32'h8000_0010, 1'b1});
        step();
        idle_a();
        chk("t1_valid", 64'(upd_a.valid), 64'd1);
        chk("t1_pc", 64'(upd_a.pc), 64'h8000_0010);
        chk("t1_taken", 64'(upd_a.taken), 64'd1);
        chk("t1_usage_1", 64'(usage_a), 64'd1);
        step();
        chk("t1_valid_after", 64'(upd_a.valid), 64'd0);
        chk("t1_usage_0", 64'(usage_a), 64'd0);

        // Back-pressure until full
        rdy_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_a(32'h100 + 32'(4 * i), i[0]);
            exp_q.push_back({32'h100 + 32'(4 * i), i[0]});
            step();
        end
        idle_a();
        chk("t2_full", 64'(full_a), 64'd1);
        chk("t2_usage", 64'(usage_a), 64'd4);
        chk("t2_head", 64'(upd_a.pc), 64'h100);

        // Overflow drops leave contents intact
        for (int i = 0; i < 3; i++) begin
            push_a(32'h900 + 32'(4 * i), 1'b1);
            step();
        end
        idle_a();
        chk("t3_drop", 64'(drop_a), 64'd3);
        chk("t3_usage", 64'(usage_a), 64'd4);
        chk("t3_head", 64'(upd_a.pc), 64'h100);

        // Full with simultaneous push and pop
        rdy_a = 1'b1;
        push_a(32'h200, 1'b0);
        exp_q.push_back({32'h200, 1'b0});
        step();
        idle_a();
        chk("t4_usage", 64'(usage_a), 64'd4);
        chk("t4_full", 64'(full_a), 64'd1);
        chk("t4_drop", 64'(drop_a), 64'd3);
        chk("t4_head", 64'(upd_a.pc), 64'h104);
        repeat (4) step();
        chk("t4_drained_valid", 64'(upd_a.valid), 64'd0);
        chk("t4_drained_usage", 64'(usage_a), 64'd0);

        // Filtering: non-conditional and debug-mode resolutions
        rdy_a = 1'b0;
        rv_a = 1'b1; rc_a = 1'b0; rpc_a = 32'hA00; rt_a = 1'b1;
        step();
        idle_a();
        chk("t5_noncond_usage", 64'(usage_a), 64'd0);
        dbg_a = 1'b1;
        push_a(32'hB00, 1'b1);
        step();
        idle_a();
        chk("t5_debug_usage", 64'(usage_a), 64'd0);
        dbg_a = 1'b0;
        push_a(32'h400, 1'b1);
        exp_q.push_back({32'h400, 1'b1});
        step();
        push_a(32'h404, 1'b0);
        exp_q.push_back({32'h404, 1'b0});
        step();
        idle_a();
        chk("t5_queued", 64'(usage_a), 64'd2);
        dbg_a = 1'b1;
        rdy_a = 1'b1;
        push_a(32'hC00, 1'b1);
        step();
        chk("t5_debug_drain1", 64'(usage_a), 64'd1);
        step();
        chk("t5_debug_drain0", 64'(usage_a), 64'd0);
        chk("t5_debug_valid", 64'(upd_a.valid), 64'd0);
        idle_a();
        dbg_a = 1'b0;
        rdy_a = 1'b0;

        // Flush with a concurrent push
        for (int i = 0; i < 3; i++) begin
            push_a(32'h500 + 32'(4 * i), 1'b1);
            step();
        end
        idle_a();
        chk("t6_queued", 64'(usage_a), 64'd3);
        flush_a = 1'b1;
        push_a(32'h50C, 1'b1);
        step();
        flush_a = 1'b0;
        idle_a();
        chk("t6_flush_valid", 64'(upd_a.valid), 64'd0);
        chk("t6_flush_usage", 64'(usage_a), 64'd0);
        chk("t6_flush_drop", 64'(drop_a), 64'd3);
        rdy_a = 1'b1;
        push_a(32'h300, 1'b1);
        exp_q.push_back({32'h300, 1'b1});
        step();
        idle_a();
        chk("t6_post_valid", 64'(upd_a.valid), 64'd1);
        chk("t6_post_pc", 64'(upd_a.pc), 64'h300);
        step();
        chk("t6_post_usage", 64'(usage_a), 64'd0);

        // Asynchronous reset mid-queue
        rdy_a = 1'b0;
        push_a(32'h600, 1'b1);
        step();
        push_a(32'h604, 1'b0);
        step();
        idle_a();
        chk("t7_queued", 64'(usage_a), 64'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t7_rst_upd", 64'(upd_a), 64'd0);
        chk("t7_rst_usage", 64'(usage_a), 64'd0);
        chk("t7_rst_full", 64'(full_a), 64'd0);
        chk("t7_rst_drop", 64'(drop_a), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // DebugEn=0 accepts debug-mode pushes; 2-bit drop counter saturates
        rdy_b = 1'b0;
        dbg_b = 1'b1;
        push_b(32'h700, 1'b1);
        step();
        idle_b();
        chk("t8_usage", 64'(usage_b), 64'd1);
        chk("t8_valid", 64'(upd_b.valid), 64'd1);
        chk("t8_pc", 64'(upd_b.pc), 64'h700);
        for (int i = 1; i < 4; i++) begin
            push_b(32'h700 + 32'(4 * i), 1'b0);
            step();
        end
        idle_b();
        chk("t8_full", 64'(full_b), 64'd1);
        for (int i = 0; i < 2; i++) begin
            push_b(32'hD00 + 32'(4 * i), 1'b1);
            step();
        end
        idle_b();
        chk("t8_drop2", 64'(drop_b), 64'd2);
        for (int i = 0; i < 3; i++) begin
            push_b(32'hE00 + 32'(4 * i), 1'b1);
            step();
        end
        idle_b();
        chk("t8_drop_sat", 64'(drop_b), 64'd3);
        chk("t8_usage_full", 64'(usage_b), 64'd4);
        chk("t8_head", 64'(upd_b.pc), 64'h700);
        dbg_b = 1'b0;

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
